rp_sdarb: RTL and testbench
===========================

RP_SDARB -- requirements
Module: rp_sdarb

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 24'd10000000, giving the maximum clk cycles spent in XFER before abort.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 The block SHALL have port clr, input, 1 bit: synchronous clear (massbus INIT).
REQ-006 The block SHALL have port rpSDREQ, input, 8 bits: per-drive SD request, level.
REQ-007 The block SHALL have port rpSDOP, input, 24 bits: 3-bit SD operation per drive, drive n at [3n+2:3n].
REQ-008 The block SHALL have port rpSDLSA, input, 168 bits: 21-bit linear sector address per drive, drive n at [21n+20:21n].
REQ-009 The block SHALL have port rpSDACK, output, 8 bits: per-drive completion pulse.
REQ-010 The block SHALL have port sdREQ, output, 1 bit: transfer request to SD controller, level.
REQ-011 The block SHALL have port sdOP, output, 3 bits: latched operation of the granted drive.
REQ-012 The block SHALL have port sdLSA, output, 21 bits: latched sector address of the granted drive.
REQ-013 The block SHALL have port sdSCAN, output, 3 bits: index of the granted drive.
REQ-014 The block SHALL have port sdDONE, input, 1 bit: one-cycle completion pulse from the SD controller.
REQ-015 The block SHALL have port arbBUSY, output, 1 bit: high whenever state is not IDLE.
REQ-016 The block SHALL have port arbTMO, output, 1 bit: sticky timeout flag.

Function
REQ-017 The block SHALL implement four states, IDLE, XFER, ACK and GAP, with transitions IDLE->XFER, XFER->ACK, ACK->GAP and GAP->IDLE.
REQ-018 In IDLE with any rpSDREQ bit set, the block SHALL pick the first requesting drive searching round-robin from (last+1) mod 8 upward with wrap.
REQ-019 On that pick, the block SHALL latch sdSCAN, sdOP and sdLSA from the picked drive in the same cycle and enter XFER.
REQ-020 sdREQ SHALL be high in the cycle after the request is seen and remain high for the whole of XFER.
REQ-021 sdOP, sdLSA and sdSCAN SHALL stay stable from XFER entry until the next grant.
REQ-022 Changes on rpSDOP, rpSDLSA or rpSDREQ during XFER SHALL have no effect on the current transfer.
REQ-023 A 24-bit timeout counter SHALL clear on XFER entry and increment each XFER cycle.
REQ-024 In XFER, sdDONE SHALL move the state to ACK.
REQ-025 In XFER, a counter value of TIMEOUT-1 without sdDONE SHALL set arbTMO and move the state to ACK.
REQ-026 If sdDONE and the timeout occur in the same cycle, sdDONE SHALL win and arbTMO SHALL not be set.
REQ-027 In ACK, sdREQ SHALL be 0 and rpSDACK[sdSCAN] SHALL be 1 for exactly one cycle, all other ack bits 0.
REQ-028 In ACK, last SHALL be updated to sdSCAN.
REQ-029 GAP SHALL last one cycle with no grant, giving the acknowledged drive time to drop its request.
REQ-030 sdDONE outside XFER SHALL be ignored.
REQ-031 arbTMO SHALL stay set until rst or clr.
REQ-032 clr SHALL force IDLE in the next cycle with sdREQ=0, rpSDACK=0, arbTMO=0 and last=7, and no ack for an aborted transfer.
REQ-033 If clr and sdDONE occur in the same cycle, clr SHALL win.

Reset
REQ-034 On rst, outputs SHALL reset to sdREQ=0, sdOP=0, sdLSA=0, sdSCAN=0, rpSDACK=0, arbBUSY=0 and arbTMO=0.
REQ-035 On rst, internal state SHALL reset to state=IDLE, last=7 and counter=0.
REQ-036 Reset assertion mid-transfer SHALL abort the transfer immediately without an ack pulse.

Verification
REQ-037 After reset, drive 3 requesting with op=2 and LSA=21'h00123 -> next cycle sdREQ=1, sdSCAN=3, sdOP=2, sdLSA=21'h00123; sdDONE pulse -> rpSDACK=8'h08 for one cycle, then arbBUSY=0 two cycles later.
REQ-038 All 8 drives requesting continuously from reset, with sdDONE 4 cycles after each sdREQ -> grant order 0,1,2,...,7,0 and no drive granted twice in a row.
REQ-039 With last=5 and requests on drives 2 and 6 -> drive 6 granted first, then drive 2.
REQ-040 With TIMEOUT=16 and no sdDONE -> ACK entered after 16 XFER cycles, arbTMO=1 and ack pulse to the granted drive; arbTMO stays 1 across later grants until clr.
REQ-041 clr asserted on the 3rd XFER cycle -> next cycle sdREQ=0, IDLE and no rpSDACK; a later request from drive 0 is granted first.
REQ-042 sdDONE pulsed in IDLE and in GAP -> no state change and no ack.

Source files
------------

// File: rtl/rp_sdarb.sv
// rp_sdarb: round-robin arbiter granting one of eight drives access to a
// single SD controller. Each grant latches the drive's operation and sector
// address, holds sdREQ through the transfer, then pulses a per-drive ack. A
// watchdog aborts a transfer that never completes and sets a sticky flag.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   clr           synchronous clear (massbus INIT)
//   rpSDREQ       per-drive request level
//   rpSDOP        per-drive 3-bit operation, drive n at [3n+2:3n]
//   rpSDLSA       per-drive 21-bit sector address, drive n at [21n+20:21n]
//   rpSDACK       per-drive one-cycle completion pulse
//   sdREQ         transfer request to SD controller
//   sdOP/sdLSA    latched operation / sector address of the granted drive
//   sdSCAN        index of the granted drive
//   sdDONE        one-cycle completion pulse from the SD controller
//   arbBUSY       high whenever the arbiter is not idle
//   arbTMO        sticky timeout flag
module rp_sdarb #(
    parameter logic [23:0] TIMEOUT = 24'd10000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [7:0]   rpSDREQ,
    input  logic [23:0]  rpSDOP,
    input  logic [167:0] rpSDLSA,
    output logic [7:0]   rpSDACK,
    output logic         sdREQ,
    output logic [2:0]   sdOP,
    output logic [20:0]  sdLSA,
    output logic [2:0]   sdSCAN,
    input  logic         sdDONE,
    output logic         arbBUSY,
    output logic         arbTMO
);

    localparam int unsigned NDRV  = 8;
    localparam int unsigned OP_W  = 3;
    localparam int unsigned LSA_W = 21;
    localparam int unsigned CNT_W = 24;

    typedef enum logic [1:0] {IDLE, XFER, ACK, GAP} state_t;

    state_t             state_q, state_d;
    logic [2:0]         last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         scan_q, scan_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [LSA_W-1:0]   lsa_q, lsa_d;
    logic               req_q, req_d;
    logic [NDRV-1:0]    ack_q, ack_d;
    logic               busy_q, busy_d;
    logic               tmo_q, tmo_d;

    logic               pick_vld;
    logic [2:0]         pick_idx;
    logic [2:0]         cand;

    // Round-robin search starting just after the last acknowledged drive.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = 3'd0;
        cand     = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            cand = last_q + 3'(k);
            if (!pick_vld && rpSDREQ[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        scan_d  = scan_q;
        op_d    = op_q;
        lsa_d   = lsa_q;
        req_d   = req_q;
        ack_d   = '0;
        tmo_d   = tmo_q;
        if (clr) begin
            // Aborted transfers get no ack; grant fields are left as-is.
            state_d = IDLE;
            last_d  = 3'd7;
            cnt_d   = '0;
            req_d   = 1'b0;
            tmo_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        state_d = XFER;
                        scan_d  = pick_idx;
                        op_d    = rpSDOP[5'(pick_idx) * 5'd3 +: OP_W];
                        lsa_d   = rpSDLSA[8'(pick_idx) * 8'd21 +: LSA_W];
                        req_d   = 1'b1;
                        cnt_d   = '0;
                    end
                end
                XFER: begin
                    // Completion takes priority over a coincident timeout.
                    if (sdDONE) begin
                        state_d = ACK;
                        req_d   = 1'b0;
                        ack_d   = 8'd1 << scan_q;
                    end else if (cnt_q == TIMEOUT - 24'd1) begin
                        state_d = ACK;
                        req_d   = 1'b0;
                        ack_d   = 8'd1 << scan_q;
                        tmo_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 24'd1;
                    end
                end
                ACK: begin
                    state_d = GAP;
                    last_d  = scan_q;
                end
                GAP: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 3'd7;
            cnt_q   <= '0;
            scan_q  <= '0;
            op_q    <= '0;
            lsa_q   <= '0;
            req_q   <= 1'b0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            scan_q  <= scan_d;
            op_q    <= op_d;
            lsa_q   <= lsa_d;
            req_q   <= req_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
        end
    end

    assign rpSDACK = ack_q;
    assign sdREQ   = req_q;
    assign sdOP    = op_q;
    assign sdLSA   = lsa_q;
    assign sdSCAN  = scan_q;
    assign arbBUSY = busy_q;
    assign arbTMO  = tmo_q;

endmodule

// File: tb/tb_rp_sdarb.sv
// Testbench for rp_sdarb: directed table of grants, hand sequences for clear,
// continuous round-robin and stray sdDONE, then random transactions checked
// against a transaction-level round-robin model.
module tb_rp_sdarb;

    localparam logic [23:0] TMO = 24'd16;
    localparam int TMO_I = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         clr;
    logic [7:0]   rpSDREQ;
    logic [23:0]  rpSDOP;
    logic [167:0] rpSDLSA;
    logic [7:0]   rpSDACK;
    logic         sdREQ;
    logic [2:0]   sdOP;
    logic [20:0]  sdLSA;
    logic [2:0]   sdSCAN;
    logic         sdDONE;
    logic         arbBUSY;
    logic         arbTMO;

    rp_sdarb #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .rpSDREQ(rpSDREQ), .rpSDOP(rpSDOP), .rpSDLSA(rpSDLSA),
        .rpSDACK(rpSDACK), .sdREQ(sdREQ), .sdOP(sdOP), .sdLSA(sdLSA),
        .sdSCAN(sdSCAN), .sdDONE(sdDONE), .arbBUSY(arbBUSY), .arbTMO(arbTMO)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [2:0]  op_arr  [8];
    logic [20:0] lsa_arr [8];

    typedef struct {
        logic [7:0] mask;
        int         delay;
        logic [2:0] exp_scan;
        logic       exp_tmo;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_fields();
        for (int d = 0; d < 8; d++) begin
            rpSDOP[d*3 +: 3]    = op_arr[d];
            rpSDLSA[d*21 +: 21] = lsa_arr[d];
        end
    endtask

    task automatic rand_fields();
        for (int d = 0; d < 8; d++) begin
            op_arr[d]  = 3'($urandom);
            lsa_arr[d] = 21'($urandom);
        end
        drive_fields();
    endtask

    // One complete grant: request -> XFER -> ACK -> GAP -> IDLE, starting in IDLE.
    task automatic txn(input logic [7:0] mask, input int delay,
                       input logic [2:0] exp_scan, input logic exp_tmo);
        int          wait_n;
        int          k;
        int          exp_len;
        logic [2:0]  e_op;
        logic [20:0] e_lsa;
        e_op  = op_arr[exp_scan];
        e_lsa = lsa_arr[exp_scan];
        rpSDREQ = mask;
        wait_n = 0;
        do begin
            tick();
            wait_n++;
        end while (!sdREQ && wait_n < 10);
        check("grant_latency", 32'(wait_n), 32'd1);
        check("grant_scan", 32'(sdSCAN), 32'(exp_scan));
        check("grant_op", 32'(sdOP), 32'(e_op));
        check("grant_lsa", 32'(sdLSA), 32'(e_lsa));
        check("busy_xfer", 32'(arbBUSY), 32'd1);
        // Scramble the drive-side inputs; the transfer must not see it.
        rand_fields();
        k = 1;
        forever begin
            if (k == delay) sdDONE = 1'b1;
            tick();
            sdDONE = 1'b0;
            if (rpSDACK != 8'd0 || k >= 40) break;
            k++;
        end
        exp_len = (delay >= 1 && delay <= TMO_I) ? delay : TMO_I;
        check("xfer_len", 32'(k), 32'(exp_len));
        check("ack_bits", 32'(rpSDACK), 32'(8'd1 << exp_scan));
        check("ack_sdreq", 32'(sdREQ), 32'd0);
        check("ack_tmo", 32'(arbTMO), 32'(exp_tmo));
        check("hold_op", 32'(sdOP), 32'(e_op));
        check("hold_lsa", 32'(sdLSA), 32'(e_lsa));
        rpSDREQ = 8'd0;
        tick();
        check("gap_ack", 32'(rpSDACK), 32'd0);
        check("gap_busy", 32'(arbBUSY), 32'd1);
        sdDONE = 1'b1;
        tick();
        sdDONE = 1'b0;
        check("idle_busy", 32'(arbBUSY), 32'd0);
        check("idle_ack", 32'(rpSDACK), 32'd0);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Reference round-robin pick from the last granted drive.
    function automatic logic [2:0] rr_pick(input logic [7:0] mask, input int last);
        for (int k = 1; k <= 8; k++)
            if (mask[(last + k) % 8]) return 3'((last + k) % 8);
        return 3'd0;
    endfunction

    initial begin
        int         last_m;
        logic       tmo_m;
        logic [7:0] m;
        int         dly;
        logic [2:0] es;
        logic [2:0] prev;
        int         w;

        rst = 1'b1; clr = 1'b0; rpSDREQ = '0; rpSDOP = '0; rpSDLSA = '0; sdDONE = 1'b0;
        for (int d = 0; d < 8; d++) begin op_arr[d] = '0; lsa_arr[d] = '0; end
        repeat (3) tick();
        check("rst_sdreq", 32'(sdREQ), 32'd0);
        check("rst_op", 32'(sdOP), 32'd0);
        check("rst_lsa", 32'(sdLSA), 32'd0);
        check("rst_scan", 32'(sdSCAN), 32'd0);
        check("rst_ack", 32'(rpSDACK), 32'd0);
        check("rst_busy", 32'(arbBUSY), 32'd0);
        check("rst_tmo", 32'(arbTMO), 32'd0);
        rst = 1'b0;
        tick();

        // Stray sdDONE in IDLE.
        sdDONE = 1'b1;
        tick();
        sdDONE = 1'b0;
        tick();
        check("idle_done_busy", 32'(arbBUSY), 32'd0);
        check("idle_done_ack", 32'(rpSDACK), 32'd0);

        // Directed grant table (last starts at 7).
        vecs[0] = '{8'h08, 3,  3'd3, 1'b0};
        vecs[1] = '{8'h20, 1,  3'd5, 1'b0};
        vecs[2] = '{8'h44, 5,  3'd6, 1'b0};
        vecs[3] = '{8'h44, 16, 3'd2, 1'b0};
        vecs[4] = '{8'hFF, 2,  3'd3, 1'b0};
        vecs[5] = '{8'h02, 99, 3'd1, 1'b1};
        vecs[6] = '{8'h81, 4,  3'd7, 1'b1};
        vecs[7] = '{8'h81, 7,  3'd0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            rand_fields();
            if (i == 0) begin
                op_arr[3]  = 3'd2;
                lsa_arr[3] = 21'h00123;
                drive_fields();
            end
            txn(vecs[i].mask, vecs[i].delay, vecs[i].exp_scan, vecs[i].exp_tmo);
        end

        // Clear on the 3rd XFER cycle of a drive-3 grant; last was 0.
        rand_fields();
        rpSDREQ = 8'h08;
        tick();
        check("clr_grant", 32'(sdSCAN), 32'd3);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        rpSDREQ = 8'h00;
        check("clr_sdreq", 32'(sdREQ), 32'd0);
        check("clr_busy", 32'(arbBUSY), 32'd0);
        check("clr_ack", 32'(rpSDACK), 32'd0);
        check("clr_tmo", 32'(arbTMO), 32'd0);
        tick();
        check("clr_noack", 32'(rpSDACK), 32'd0);
        rand_fields();
        txn(8'h81, 3, 3'd0, 1'b0);

        // All drives requesting continuously from a clear.
        do_clr();
        rpSDREQ = 8'hFF;
        prev = 3'd7;
        for (int i = 0; i < 9; i++) begin
            w = 0;
            while (!sdREQ && w < 10) begin tick(); w++; end
            check("rr_wait", 32'(sdREQ), 32'd1);
            check("rr_order", 32'(sdSCAN), 32'(i % 8));
            total++;
            if (i > 0 && sdSCAN == prev) begin
                bad++;
                $display("FAIL rr_repeat: got %0d twice", sdSCAN);
            end
            prev = sdSCAN;
            repeat (3) tick();
            sdDONE = 1'b1;
            tick();
            sdDONE = 1'b0;
            check("rr_ack", 32'(rpSDACK), 32'(8'd1 << (i % 8)));
        end
        rpSDREQ = 8'h00;
        repeat (3) tick();

        // Random transactions against the round-robin model.
        do_clr();
        last_m = 7;
        tmo_m  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            m   = 8'($urandom_range(1, 255));
            dly = $urandom_range(1, 20);
            es  = rr_pick(m, last_m);
            if (dly > TMO_I) tmo_m = 1'b1;
            rand_fields();
            txn(m, dly, es, tmo_m);
            last_m = int'(es);
        end

        // Reset mid-transfer aborts with no ack.
        rpSDREQ = 8'h10;
        repeat (3) tick();
        rst = 1'b1;
        #2;
        check("rst_mid_sdreq", 32'(sdREQ), 32'd0);
        check("rst_mid_busy", 32'(arbBUSY), 32'd0);
        rpSDREQ = 8'h00;
        tick();
        rst = 1'b0;
        tick();
        check("rst_mid_ack", 32'(rpSDACK), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
